// File: rtl/alu_pkg.sv
// Shared opcode constants, ALU control encodings and sequencer state type
// for the SIMD ALU control path.
package alu_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SUBI = 3'b101;
  localparam logic [2:0] OP_MULI = 3'b110;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: opcode/funct/ALUOp to ALU control word,
// immediate select and multi-cycle flag.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPW = 3,
  parameter int CW  = 3
) (
  input  logic [OPW-1:0] opcode,
  input  logic [CW-1:0]  funct,
  input  logic           alu_op,
  output logic [CW-1:0]  control,
  output logic           sel,
  output logic           is_multi
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    control = CW'(ALU_ADD);
    sel     = 1'b0;
    if (alu_op) begin
      if (opcode == OPW'(OP_R)) begin
        control = funct;
      end else if (opcode == OPW'(OP_ADDI)) begin
        control = CW'(ALU_ADD);
        sel     = 1'b1;
      end else if (opcode == OPW'(OP_SUBI)) begin
        control = CW'(ALU_SUB);
        sel     = 1'b1;
      end else if (opcode == OPW'(OP_MULI)) begin
        control = CW'(ALU_MUL);
        sel     = 1'b1;
      end
    end
  end

  // An R-type funct of MUL is a multiply too, not just MULI.
  assign is_multi = (control == CW'(ALU_MUL));

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// ALU control sequencer: accepts decoded instructions, stretches multiplies
// over MUL_CYCLES and holds a registered control word until consumed.
module alu_ctrl_sequencer
  import alu_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int OPW        = 3,
  parameter int CW         = 3,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   Opcode,
  input  logic [CW-1:0]    Funct,
  input  logic             ALUOp,
  input  logic [LANES-1:0] LaneMask,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    ALUControl,
  output logic             ALUSel,
  output logic [LANES-1:0] LaneEn,
  output logic             busy
);

  localparam int CNT_W = ($clog2(MUL_CYCLES + 1) < 1) ? 1 : $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0]    dec_control;
  logic             dec_sel;
  logic             dec_multi;
  logic             accept;
  logic             bubble;

  alu_op_decode #(
    .OPW(OPW),
    .CW (CW)
  ) u_decode (
    .opcode  (Opcode),
    .funct   (Funct),
    .alu_op  (ALUOp),
    .control (dec_control),
    .sel     (dec_sel),
    .is_multi(dec_multi)
  );

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (flush) in_ready = 1'b0;
  end

  assign accept = in_valid && in_ready;
  assign bubble = (LaneMask == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      ALUControl <= '0;
      ALUSel     <= 1'b0;
      LaneEn     <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept && !bubble) begin
            ALUControl <= dec_control;
            ALUSel     <= dec_sel;
            LaneEn     <= LaneMask;
            if (dec_multi && (MUL_CYCLES > 1)) begin
              state     <= ST_EXEC;
              cnt       <= CNT_LOAD;
              out_valid <= 1'b0;
              busy      <= 1'b1;
            end else begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (accept || (state == ST_HOLD && out_ready)) begin
            // Consumed word with no useful successor (or an all-lanes-off bubble).
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (cnt == CNT_W'(1)) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_ctrl_sequencer.md
ALU_CTRL_SEQUENCER -- requirements
Module: alu_ctrl_sequencer

Interface
REQ-001 Parameter LANES, default 4: number of SIMD ALU lanes controlled.
REQ-002 Parameter OPW, default 3: opcode width.
REQ-003 Parameter CW, default 3: ALU control / funct width.
REQ-004 Parameter MUL_CYCLES, default 3, legal range 1..15: total latency of a multiply, accept to out_valid.
REQ-005 clk  in  1  single system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  upstream instruction present.
REQ-008 in_ready  out  1  sequencer accepts the instruction this cycle.
REQ-009 Opcode  in  OPW  instruction opcode.
REQ-010 Funct  in  CW  R-type function field.
REQ-011 ALUOp  in  1  1 = data-processing instruction; 0 = non-DP (forced add).
REQ-012 LaneMask  in  LANES  per-lane execute enable.
REQ-013 flush  in  1  synchronous pipeline flush.
REQ-014 out_valid  out  1  registered control word valid.
REQ-015 out_ready  in  1  execute stage consumes the control word.
REQ-016 ALUControl  out  CW  registered ALU operation.
REQ-017 ALUSel  out  1  registered immediate-operand select.
REQ-018 LaneEn  out  LANES  registered lane enables.
REQ-019 busy  out  1  high while a multiply is counting.

Function
REQ-020 Decode on accept (in_valid && in_ready): ALUOp=0 -> ALUControl 000, ALUSel 0; Opcode 000 -> Funct, ALUSel 0; 100 -> 000, 101 -> 001, 110 -> 010, each ALUSel 1; any other opcode -> 000, ALUSel 0.
REQ-021 A decoded ALUControl of 010 (multiply) is a multi-cycle op; all others are single-cycle.
REQ-022 FSM states IDLE, EXEC, HOLD; reset state IDLE.
REQ-023 IDLE: in_ready=1; accept single-cycle -> HOLD; accept multiply with MUL_CYCLES=1 -> HOLD; accept multiply with MUL_CYCLES>1 -> EXEC, counter loaded with MUL_CYCLES-1.
REQ-024 EXEC: in_ready=0, busy=1, counter decrements each cycle; at counter 1 -> HOLD next cycle.
REQ-025 HOLD: out_valid=1; outputs stable while out_ready=0; in_ready=out_ready.
REQ-026 HOLD with out_ready=1 and new accept: back-to-back handoff, same transitions as IDLE, no bubble cycle.
REQ-027 HOLD with out_ready=1 and no accept -> IDLE, out_valid 0 next cycle.
REQ-028 Latency: single-cycle op out_valid 1 cycle after accept; multiply out_valid MUL_CYCLES cycles after accept.
REQ-029 LaneMask all-zero on accept: instruction is consumed (in_ready honoured) but treated as a bubble: state stays/returns IDLE, no out_valid.
REQ-030 flush=1: next state IDLE, out_valid 0, counter cleared; overrides simultaneous in_valid (no accept, in_ready forced 0 that cycle) and any EXEC count.
REQ-031 Outputs ALUControl, ALUSel, LaneEn change only on accept; hold last value otherwise.

Reset
REQ-032 rst low asynchronously forces IDLE, counter 0, out_valid 0, busy 0, ALUControl 000, ALUSel 0, LaneEn all zero.
REQ-033 Reset mid-EXEC or mid-HOLD discards the instruction; in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-034 Shared package alu_pkg holds opcode constants (R, ADDI, SUBI, MULI), ALU control encodings (ADD 000, SUB 001, MUL 010) and the FSM state enum.
REQ-035 Combinational decode is a sub-module alu_op_decode (Opcode, Funct, ALUOp -> control, sel, is_multi); sequencer holds FSM, counter and output registers.
REQ-036 Counter width $clog2(MUL_CYCLES+1), minimum 1 bit.

Verification
REQ-037 Reset, then accept Opcode 000 Funct 011 mask 1111, out_ready 1 -> next cycle out_valid 1, ALUControl 011, ALUSel 0, LaneEn 1111.
REQ-038 Accept Opcode 110 (MUL_CYCLES=3) -> busy 1 for 2 cycles, in_ready 0, out_valid at cycle 3, ALUControl 010, ALUSel 1.
REQ-039 Three back-to-back addi/subi/R accepts, out_ready 1 -> out_valid continuous 3 cycles, ALUControl 000, 001, Funct.
REQ-040 HOLD with out_ready 0 for 4 cycles -> outputs stable, in_ready 0; out_ready 1 -> consumed, in_ready 1 same cycle.
REQ-041 flush during EXEC count 1 with in_valid 1 -> no accept, IDLE next cycle, out_valid never asserts.
REQ-042 Accept with LaneMask 0000, then rst pulse mid-multiply -> no out_valid; all outputs at reset values asynchronously.
